// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } arb_state_e;

  localparam int VAL_W_DEF = 14;
  localparam int BCD_W     = 16;
  localparam int MAX_BCD   = 9999;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request strictly after ptr_i, wrapping.
module rr_priority_picker
  import bcd_arb_pkg::*;
#(
  parameter  int NREQ  = 3,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] j;

  // Scan farthest-first so the nearest candidate after ptr_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin sharing of one binary-to-BCD converter between NREQ sources.
// Define CLAMP_9999_EN to saturate requested values at 9999 before conversion.
module bcd_convert_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*VAL_W-1:0] req_val,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ*BCD_W-1:0] result,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  conv_start,
  output logic [VAL_W-1:0]      conv_val,
  input  logic [BCD_W-1:0]      conv_bcd,
  input  logic                  conv_done
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  arb_state_e                   state_q;
  logic [IDX_W-1:0]             ptr_q, g_q;
  logic [WD_W-1:0]              wd_q;
  logic [NREQ-1:0]              ack_q;
  logic [NREQ-1:0][BCD_W-1:0]   result_q;
  logic                         conv_start_q, terr_q, busy_q;
  logic [VAL_W-1:0]             conv_val_q;

  logic [NREQ-1:0][VAL_W-1:0]   req_vec;
  logic [VAL_W-1:0]             sel_val, lat_val;
  logic                         pick_vld;
  logic [IDX_W-1:0]             pick_idx;

  assign req_vec = req_val;

  // A requester whose ack is showing this cycle is not yet allowed back in.
  rr_priority_picker #(.NREQ(NREQ)) u_pick (
    .req_i   (req & ~ack_q),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign sel_val = req_vec[pick_idx];

`ifdef CLAMP_9999_EN
  assign lat_val = (sel_val > VAL_W'(MAX_BCD)) ? VAL_W'(MAX_BCD) : sel_val;
`else
  assign lat_val = sel_val;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NREQ-1);
      g_q          <= '0;
      wd_q         <= '0;
      ack_q        <= '0;
      result_q     <= '0;
      conv_start_q <= 1'b0;
      conv_val_q   <= '0;
      terr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ack_q        <= '0;
      conv_start_q <= 1'b0;
      terr_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            g_q          <= pick_idx;
            conv_val_q   <= lat_val;
            conv_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Digits are taken while conv_done is present so result and ack appear together.
          if (conv_done) begin
            result_q[g_q] <= conv_bcd;
            ack_q[g_q]    <= 1'b1;
            state_q       <= CAPTURE;
          end else if (wd_q == WD_W'(TIMEOUT-2)) begin
            terr_q     <= 1'b1;
            ack_q[g_q] <= 1'b1;
            ptr_q      <= g_q;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        CAPTURE: begin
          ptr_q   <= g_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign conv_start  = conv_start_q;
  assign conv_val    = conv_val_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard bench for bcd_convert_arbiter with a behavioural converter stub.
module tb_bcd_convert_arbiter;
  localparam int NREQ = 3, VAL_W = 14, TIMEOUT = 64;

  logic clk = 1'b0, reset;
  logic [NREQ-1:0]       req, ack;
  logic [NREQ*VAL_W-1:0] req_val;
  logic [NREQ*16-1:0]    result;
  logic                  busy, timeout_err, conv_start, conv_done;
  logic [VAL_W-1:0]      conv_val;
  logic [15:0]           conv_bcd;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  bit stub_hang = 0;
  int inject_req = 0;
  int want [NREQ];

  always #5 clk = ~clk;

  bcd_convert_arbiter #(.NREQ(NREQ), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_val(req_val), .ack(ack),
    .result(result), .busy(busy), .timeout_err(timeout_err),
    .conv_start(conv_start), .conv_val(conv_val), .conv_bcd(conv_bcd),
    .conv_done(conv_done)
  );

  function automatic logic [15:0] to_bcd(int v);
    int x;
    x = v % 10000;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic int clampv(int v);
`ifdef CLAMP_9999_EN
    return (v > 9999) ? 9999 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Inputs as the DUT saw them on the last rising edge.
  logic [NREQ-1:0]       req_smp;
  logic [NREQ*VAL_W-1:0] rv_smp;
  logic                  done_smp;
  always @(posedge clk) begin
    req_smp  <= req;
    rv_smp   <= req_val;
    done_smp <= conv_done;
  end

  // Converter stub: random latency, or silent when stub_hang; stray pulses on request.
  initial begin
    int lat, seen;
    bit aborted;
    conv_done = 1'b0;
    conv_bcd  = '0;
    seen      = 0;
    forever begin
      @(negedge clk);
      if (inject_req != seen) begin
        seen      = inject_req;
        conv_done = 1'b1;
        conv_bcd  = 16'h5555;
        @(negedge clk);
        conv_done = 1'b0;
      end else if (conv_start && !stub_hang && !reset) begin
        lat     = $urandom_range(3, 40);
        aborted = 0;
        repeat (lat - 1) begin
          @(negedge clk);
          if (reset) aborted = 1;
        end
        if (!aborted) begin
          conv_done = 1'b1;
          conv_bcd  = to_bcd(int'(conv_val));
          @(negedge clk);
          conv_done = 1'b0;
        end
      end
    end
  end

  // Reference: one grant outstanding at a time, chosen round-robin after the last acked index.
  typedef struct { int g; int val; int start; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          ptr_m, g, done_cyc;
  bit          got_done, busy_chk0;
  logic [15:0] res_m [NREQ];
  logic [NREQ*16-1:0] res_vec;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sb.delete();
      ptr_m     = NREQ - 1;
      got_done  = 0;
      busy_chk0 = 0;
      for (int i = 0; i < NREQ; i++) res_m[i] = '0;
    end else begin
      if (busy_chk0) begin
        check("busy_low_after_capture", 64'(busy), 64'(0));
        busy_chk0 = 0;
      end
      if (conv_start) begin
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && req_smp[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
        end
        check("start_has_pending_req", 64'(g >= 0 && sb.size() == 0), 64'(1));
        if (g >= 0) begin
          e.g     = g;
          e.val   = clampv(int'(rv_smp[g*VAL_W +: VAL_W]));
          e.start = cyc;
          check("conv_val", 64'(conv_val), 64'(e.val));
          check("busy_at_start", 64'(busy), 64'(1));
          sb.push_back(e);
          got_done = 0;
        end
      end
      if (sb.size() > 0 && done_smp && !got_done && cyc >= sb[0].start + 2) begin
        got_done = 1;
        done_cyc = cyc;
      end
      if (ack != '0 || timeout_err) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {ack, timeout_err}, 64'(0));
        end else begin
          e = sb.pop_front();
          check("ack_vector", 64'(ack), 64'(1) << e.g);
          check("ack_cycle", 64'(cyc), 64'(got_done ? done_cyc : e.start + TIMEOUT));
          check("timeout_err", 64'(timeout_err), 64'(!got_done));
          check("busy_at_ack", 64'(busy), 64'(got_done));
          if (got_done) begin
            res_m[e.g] = to_bcd(e.val);
            busy_chk0  = 1;
          end
          ptr_m    = e.g;
          got_done = 0;
        end
      end else if (sb.size() > 0 && cyc > sb[0].start + TIMEOUT) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack_missing: requester %0d started at %0d, no ack by %0d", sb[0].g, sb[0].start, cyc);
        void'(sb.pop_front());
      end
      for (int i = 0; i < NREQ; i++) res_vec[i*16 +: 16] = res_m[i];
      check("result", 64'(result), 64'(res_vec));
    end
  end

  // Requesters: drop on ack, raise while they still have conversions wanted.
  task automatic drive(int max_cyc);
    int n, idle, tot;
    n = 0;
    idle = 0;
    while (n < max_cyc && idle < 3) begin
      @(negedge clk);
      n++;
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && want[i] > 0 && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_val[i*VAL_W +: VAL_W] = VAL_W'($urandom_range(0, 16383));
          want[i]--;
        end
        tot += want[i];
      end
      idle = (tot == 0 && req == '0 && !busy && sb.size() == 0) ? idle + 1 : 0;
    end
    if (idle < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drive_timeout: traffic not drained in %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_in_wait(int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !conv_start) && n < max_cyc);
    check("reached_wait_state", 64'(busy && !conv_start), 64'(1));
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_val = '0;
    for (int i = 0; i < NREQ; i++) want[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_busy_start_terr", {busy, conv_start, timeout_err}, 64'(0));
    check("rst_conv_val", 64'(conv_val), 64'(0));
    reset = 1'b0;

    // Single request.
    req_val[0 +: VAL_W] = VAL_W'(1234);
    req[0] = 1'b1;
    drive(300);
    check("single_result", 64'(result[15:0]), 64'(16'h1234));

    // Round robin with all three held, then requester 0 asks again.
    req_val = {VAL_W'(987), VAL_W'(42), VAL_W'(5)};
    req     = 3'b111;
    want[0] = 1;
    drive(600);

    // Converter silent: watchdog abort on requester 1.
    stub_hang = 1;
    req_val[VAL_W +: VAL_W] = VAL_W'(777);
    req[1] = 1'b1;
    drive(300);
    stub_hang = 0;

    // Requester 2 pulses for one cycle while requester 0 is in flight.
    req_val[0 +: VAL_W] = VAL_W'(2468);
    req[0] = 1'b1;
    wait_in_wait(20);
    req_val[2*VAL_W +: VAL_W] = VAL_W'(1111);
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    drive(300);

    // Out-of-range value.
    req_val[0 +: VAL_W] = VAL_W'(16383);
    req[0] = 1'b1;
    wait_in_wait(20);
`ifdef CLAMP_9999_EN
    check("clamp_conv_val", 64'(conv_val), 64'(9999));
`else
    check("noclamp_conv_val", 64'(conv_val), 64'(16383));
`endif
    drive(300);

    // Reset during WAIT, then a stray done after release.
    stub_hang = 1;
    req_val[VAL_W +: VAL_W] = VAL_W'(321);
    req[1] = 1'b1;
    wait_in_wait(20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ack_terr_start", {ack, timeout_err, conv_start}, 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_conv_val", 64'(conv_val), 64'(0));
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    inject_req++;
    repeat (6) begin
      @(negedge clk);
      check("stray_done_busy", {busy, ack}, 64'(0));
    end
    stub_hang = 0;

    // Random traffic.
    for (int i = 0; i < NREQ; i++) want[i] = $urandom_range(8, 14);
    drive(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
